// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: the start bit begins 1 cycle after the handshake, or 2 cycles with the input FIFO.
// Backpressure: Ready is high only in IDLE, or while the FIFO is not full when UART_TX_FIFO_EN is defined.
//
// Optional feature macro: UART_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO.
// When the FIFO is present, a new frame is loaded in the last stop cycle, so frames run with no idle gap.
// Ports:
//   CLK, RST (async, active high)
//   P_DATA/Data_Valid/Ready  word input handshake
//   PAR_EN, PAR_TYP, STOP2   frame format (PAR_TYP: 0 = even, 1 = odd)
//   PRESCALE                 CLK cycles per bit (0 is treated as 1)
//   TX_OUT                   serial line, idles high
//   Busy, TX_Done            frame status; TX_Done is high in the last cycle of the final stop bit
module uart_tx_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   output logic                  Ready,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic                  TX_OUT,
   output logic                  Busy,
   output logic                  TX_Done
);

   localparam int BW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [PRESCALE_W-1:0] timer;
   logic [PRESCALE_W-1:0] p_lat;
   logic [PRESCALE_W-1:0] p_src;
   logic [PRESCALE_W-1:0] reload;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_bit;
   logic                  par_en_lat;
   logic                  stop2_lat;
   logic                  stop_cnt;   // stop bits remaining after the current one
   logic                  src_vld;
   logic [DATA_WIDTH-1:0] src_dat;
   logic                  load;
   logic                  bit_end;
   logic                  last_data;
   logic                  done_next;

   assign p_src     = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
   assign reload    = p_lat - PRESCALE_W'(1);
   assign bit_end   = (timer == '0);
   assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  last_stop;

   // The extra pointer bit separates full from empty when the index bits match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en     = Data_Valid && !full;
   assign Ready     = !full;
   assign src_vld   = !empty;
   assign src_dat   = mem[rd_ptr[AW-1:0]];
   assign last_stop = (state == STOP) && bit_end && !stop_cnt;
   assign load      = src_vld && ((state == IDLE) || last_stop);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (load)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= P_DATA;
   end
`else
   logic unused_fifo_depth;
   assign unused_fifo_depth = (FIFO_DEPTH > 0);

   assign Ready   = (state == IDLE);
   assign src_vld = Data_Valid;
   assign src_dat = P_DATA;
   assign load    = src_vld && (state == IDLE);
`endif

   // TX_Done is registered, so raise it when the next cycle is the last cycle of the final stop bit.
   assign done_next =
      ((state == STOP) && !stop_cnt && (timer == PRESCALE_W'(1))) ||
      ((state == STOP) && stop_cnt && bit_end && (reload == '0)) ||
      ((((state == DATA) && last_data && !par_en_lat) || (state == PARITY)) &&
       bit_end && (reload == '0) && !stop2_lat);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         TX_OUT     <= 1'b1;
         Busy       <= 1'b0;
         TX_Done    <= 1'b0;
         timer      <= '0;
         p_lat      <= PRESCALE_W'(1);
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         par_en_lat <= 1'b0;
         stop2_lat  <= 1'b0;
         stop_cnt   <= 1'b0;
      end else begin
         TX_Done <= done_next;
         if (load) begin
            state      <= START;
            TX_OUT     <= 1'b0;
            Busy       <= 1'b1;
            timer      <= p_src - PRESCALE_W'(1);
            p_lat      <= p_src;
            shreg      <= src_dat;
            par_bit    <= (^src_dat) ^ PAR_TYP;
            par_en_lat <= PAR_EN;
            stop2_lat  <= STOP2;
            bit_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  TX_OUT <= 1'b1;
                  Busy   <= 1'b0;
               end
               START: begin
                  if (!bit_end) timer <= timer - PRESCALE_W'(1);
                  else begin
                     state   <= DATA;
                     TX_OUT  <= shreg[0];
                     timer   <= reload;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (!bit_end) timer <= timer - PRESCALE_W'(1);
                  else begin
                     timer <= reload;
                     if (!last_data) begin
                        shreg   <= shreg >> 1;
                        TX_OUT  <= shreg[1];
                        bit_cnt <= bit_cnt + BW'(1);
                     end else if (par_en_lat) begin
                        state  <= PARITY;
                        TX_OUT <= par_bit;
                     end else begin
                        state    <= STOP;
                        TX_OUT   <= 1'b1;
                        stop_cnt <= stop2_lat;
                     end
                  end
               end
               PARITY: begin
                  if (!bit_end) timer <= timer - PRESCALE_W'(1);
                  else begin
                     state    <= STOP;
                     TX_OUT   <= 1'b1;
                     timer    <= reload;
                     stop_cnt <= stop2_lat;
                  end
               end
               STOP: begin
                  if (!bit_end) timer <= timer - PRESCALE_W'(1);
                  else if (stop_cnt) begin
                     stop_cnt <= 1'b0;
                     timer    <= reload;
                  end else begin
                     state  <= IDLE;
                     Busy   <= 1'b0;
                     TX_OUT <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  Busy   <= 1'b0;
                  TX_OUT <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg with hand-computed serial frames.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_uart_tx_cfg;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  P_DATA;
   logic        Data_Valid;
   logic        Ready;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic        STOP2;
   logic [15:0] PRESCALE;
   logic        TX_OUT;
   logic        Busy;
   logic        TX_Done;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef UART_TX_FIFO_EN
   localparam int FIFO_LAT = 2;
   logic rec [0:255];
   int   cyc;
   int   dcnt;
`else
   localparam int FIFO_LAT = 1;
`endif

   uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(16), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Ready(Ready),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
      .TX_OUT(TX_OUT), .Busy(Busy), .TX_Done(TX_Done)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame bits in time order ("0" start first), each held for p cycles, then one idle-high sample.
   function automatic logic [63:0] expand(input string bits, input int p);
      logic [63:0] v;
      int k;
      v = '0;
      k = 0;
      for (int i = 0; i < bits.len(); i++) begin
         for (int j = 0; j < p; j++) begin
            v[k] = (bits[i] == "1");
            k++;
         end
      end
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic [15:0] ps, input logic pe,
                             input logic pt, input logic s2, input int n_cyc,
                             input int chg_at, input logic [15:0] chg_val,
                             output logic [63:0] line, output int done_at,
                             output int busy_cnt, output int done_cnt);
      int w;
      line     = '0;
      done_at  = -1;
      busy_cnt = 0;
      done_cnt = 0;
      w        = 0;
      while (!Ready && w < 200) begin
         @(negedge CLK);
         w++;
      end
      check("ready_wait", Ready, 1);
      P_DATA = d; PRESCALE = ps; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
      Data_Valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (FIFO_LAT - 1) @(negedge CLK);
      // Frame settings are latched; disturb the inputs for the rest of the frame.
      P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
      check("ready_in_frame", Ready, (FIFO_LAT == 2));
      for (int k = 1; k <= n_cyc; k++) begin
         if (k == chg_at) PRESCALE = chg_val;
         line[k-1] = TX_OUT;
         if (Busy) busy_cnt++;
         if (TX_Done) begin
            done_cnt++;
            done_at = k;
         end
         if (k < n_cyc) @(negedge CLK);
      end
   endtask

   task automatic run(input string tag, input logic [7:0] d, input logic [15:0] ps,
                      input logic pe, input logic pt, input logic s2,
                      input string bits, input int p, input int chg_at, input logic [15:0] chg_val);
      logic [63:0] line;
      int done_at, busy_cnt, done_cnt, n;
      n = bits.len() * p;
      send_frame(d, ps, pe, pt, s2, n + 1, chg_at, chg_val, line, done_at, busy_cnt, done_cnt);
      check({tag, "_line"}, line, expand(bits, p));
      check({tag, "_done_at"}, done_at, n);
      check({tag, "_busy_cycles"}, busy_cnt, n);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_ready_after"}, Ready, 1);
      check({tag, "_busy_after"}, Busy, 0);
   endtask

`ifdef UART_TX_FIFO_EN
   task automatic tick();
      @(negedge CLK);
      cyc++;
      rec[cyc] = TX_OUT;
      if (TX_Done) dcnt++;
   endtask

   task automatic fifo_test();
      logic [7:0]  words [5] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
      string       fb [6] = '{"0010110101", "0100010001", "0010001001",
                              "0110011001", "0001000101", "0101010101"};
      logic [63:0] seg;
      PRESCALE = 16'd2; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      cyc = 0;
      dcnt = 0;
      rec[0] = TX_OUT;
      for (int i = 0; i < 5; i++) begin
         P_DATA = words[i];
         Data_Valid = 1'b1;
         check("fifo_ready_on_write", Ready, 1);
         tick();
      end
      check("fifo_full_ready", Ready, 0);
      P_DATA = 8'h55;
      while (!Ready && cyc < 100) tick();
      // 0x5A runs cycles 2..21; its pop of 0x11 frees a slot in cycle 22.
      check("fifo_5th_accept_cycle", cyc, 22);
      tick();
      Data_Valid = 1'b0;
      while (cyc < 122) tick();
      for (int i = 0; i < 6; i++) begin
         seg = '0;
         for (int j = 0; j < 20; j++) seg[j] = rec[2 + 20*i + j];
         check($sformatf("fifo_frame%0d", i), seg, expand(fb[i], 2) & 64'hFFFFF);
      end
      check("fifo_idle_after", rec[122], 1);
      check("fifo_busy_after", Busy, 0);
      check("fifo_done_pulses", dcnt, 6);
   endtask
`endif

   initial begin
      RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      STOP2 = 1'b0; PRESCALE = 16'd4;
      repeat (3) @(negedge CLK);
      check("rst_tx_out", TX_OUT, 1);
      check("rst_busy", Busy, 0);
      check("rst_tx_done", TX_Done, 0);
      check("rst_ready", Ready, 1);
      RST = 1'b0;
      @(negedge CLK);

      // 0xA5 LSB first = 1,0,1,0,0,1,0,1 ; P=4 -> 40 cycles
      run("a5", 8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, "0101001011", 4, 0, 16'd0);
      // 0x07 even parity -> parity bit 1 ; P=2 -> 22 cycles
      run("par_even", 8'h07, 16'd2, 1'b1, 1'b0, 1'b0, "01110000011", 2, 0, 16'd0);
      // 0x07 odd parity -> parity bit 0, two stop bits ; P=3 -> 36 cycles
      run("par_odd_stop2", 8'h07, 16'd3, 1'b1, 1'b1, 1'b1, "011100000011", 3, 0, 16'd0);
      // 0x3C LSB first = 0,0,1,1,1,1,0,0 ; PRESCALE=0 acts as 1 -> 10 cycles
      run("ps0", 8'h3C, 16'd0, 1'b0, 1'b0, 1'b0, "0001111001", 1, 0, 16'd0);
      // same with two stop bits -> 11 cycles
      run("ps0_stop2", 8'h3C, 16'd0, 1'b0, 1'b0, 1'b1, "00011110011", 1, 0, 16'd0);
      // PRESCALE changed to 1 mid-frame must not alter the 40-cycle frame
      run("ps_change", 8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, "0101001011", 4, 6, 16'd1);

`ifdef UART_TX_FIFO_EN
      fifo_test();
`endif

      // Reset in the middle of DATA (bit 1 of 0xA5 drives 0 at frame cycle 10).
      PRESCALE = 16'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      P_DATA = 8'hA5;
      Data_Valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      for (int k = 1; k < 9 + FIFO_LAT; k++) begin
         if (k == 1) P_DATA = 8'hEE;   // extra queued words that the reset must discard
         if (k == 3) Data_Valid = 1'b0;
         @(negedge CLK);
      end
      check("mid_data_line", TX_OUT, 0);
      check("mid_data_busy", Busy, 1);
      RST = 1'b1;
      #1;
      check("async_rst_tx_out", TX_OUT, 1);
      check("async_rst_busy", Busy, 0);
      check("async_rst_ready", Ready, 1);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // 0x81 LSB first = 1,0,0,0,0,0,0,1 ; P=2 -> 20 cycles, line must stay idle after
      run("after_rst", 8'h81, 16'd2, 1'b0, 1'b0, 1'b0, "0100000011", 2, 0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
